// File: rtl/test_monitor.sv
// Run-control monitor for CPU test programs: watches the retired-instruction stream
// and reports pass/fail/breakpoint/timeout with sticky status, counters and stop-PC capture.
module test_monitor #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned NUM_BP         = 2,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [31:0] PASS_INSTR     = 32'h00000073,
   parameter logic [31:0] FAIL_INSTR     = 32'h00100073
) (
   input  logic                     sysClk,
   input  logic                     sysRes,
   input  logic                     en,
   input  logic                     clear,
   input  logic                     instrValid,
   input  logic [31:0]              instrData,
   input  logic [XLEN-1:0]          pc,
   input  logic [NUM_BP*XLEN-1:0]   bpAddr,
   input  logic [NUM_BP-1:0]        bpEn,
   output logic [2:0]               status,
   output logic                     done,
   output logic [CNT_W-1:0]         cycleCount,
   output logic [CNT_W-1:0]         instrCount,
   output logic [XLEN-1:0]          stopPC,
   output logic [2:0]               bpHitIdx
);

   localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4,
      ST_BREAK   = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic [XLEN-1:0]  stop_pc_q, stop_pc_d;
   logic [2:0]       bp_idx_q, bp_idx_d;

   logic             bp_hit_c;
   logic [2:0]       bp_idx_c;

   // Breakpoint match; scanning downward leaves the lowest matching index
   always_comb begin
      bp_hit_c = 1'b0;
      bp_idx_c = 3'd0;
      for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
         if (bpEn[i] && (bpAddr[i*XLEN +: XLEN] == pc)) begin
            bp_hit_c = 1'b1;
            bp_idx_c = 3'(i);
         end
      end
   end

   // Next-state, counters and capture
   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      cyc_d     = cyc_q;
      icnt_d    = icnt_q;
      stop_pc_d = stop_pc_q;
      bp_idx_d  = bp_idx_q;

      if (clear) begin
         state_d   = ST_IDLE;
         done_d    = 1'b0;
         cyc_d     = '0;
         icnt_d    = '0;
         stop_pc_d = '0;
         bp_idx_d  = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (en) begin
                  if (cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + CNT_W'(1);
                  if (instrValid && (icnt_q != {CNT_W{1'b1}})) icnt_d = icnt_q + CNT_W'(1);

                  if (instrValid && (instrData == FAIL_INSTR)) begin
                     state_d = ST_FAIL;
                  end else if (instrValid && (instrData == PASS_INSTR)) begin
                     state_d = ST_PASS;
                  end else if (instrValid && bp_hit_c) begin
                     state_d  = ST_BREAK;
                     bp_idx_d = bp_idx_c;
                  end else if (TO_EN && (cyc_q == TO_LAST)) begin
                     state_d = ST_TIMEOUT;
                  end

                  if (state_d != ST_RUN) begin
                     done_d    = 1'b1;
                     stop_pc_d = pc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge sysClk) begin
      if (!sysRes) begin
         state_q   <= ST_IDLE;
         done_q    <= 1'b0;
         cyc_q     <= '0;
         icnt_q    <= '0;
         stop_pc_q <= '0;
         bp_idx_q  <= 3'd0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         cyc_q     <= cyc_d;
         icnt_q    <= icnt_d;
         stop_pc_q <= stop_pc_d;
         bp_idx_q  <= bp_idx_d;
      end
   end

   assign status     = state_q;
   assign done       = done_q;
   assign cycleCount = cyc_q;
   assign instrCount = icnt_q;
   assign stopPC     = stop_pc_q;
   assign bpHitIdx   = bp_idx_q;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: expected outputs are queued as stimulus is driven
// and compared one cycle later, after the clock edge that produces them.
module tb_test_monitor;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NUM_BP = 2;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned TO_CYC = 20;

   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] ECALL = 32'h00000073;
   localparam logic [31:0] EBRK  = 32'h00100073;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_PASS = 3'd2;
   localparam logic [2:0] S_FAIL = 3'd3;
   localparam logic [2:0] S_TO   = 3'd4;
   localparam logic [2:0] S_BRK  = 3'd5;

   logic                   sysClk;
   logic                   sysRes;
   logic                   en;
   logic                   clear;
   logic                   instrValid;
   logic [31:0]            instrData;
   logic [XLEN-1:0]        pc;
   logic [NUM_BP*XLEN-1:0] bpAddr;
   logic [NUM_BP-1:0]      bpEn;
   logic [2:0]             status;
   logic                   done;
   logic [CNT_W-1:0]       cycleCount;
   logic [CNT_W-1:0]       instrCount;
   logic [XLEN-1:0]        stopPC;
   logic [2:0]             bpHitIdx;

   test_monitor #(
      .XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC),
      .PASS_INSTR(ECALL), .FAIL_INSTR(EBRK)
   ) dut (
      .sysClk(sysClk), .sysRes(sysRes), .en(en), .clear(clear),
      .instrValid(instrValid), .instrData(instrData), .pc(pc),
      .bpAddr(bpAddr), .bpEn(bpEn),
      .status(status), .done(done), .cycleCount(cycleCount),
      .instrCount(instrCount), .stopPC(stopPC), .bpHitIdx(bpHitIdx)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   typedef struct packed {
      logic [2:0]  st;
      logic [31:0] cc;
      logic [31:0] ic;
      logic [31:0] spc;
      logic [2:0]  bi;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st, input int unsigned cc,
                             input int unsigned ic, input logic [31:0] spc, input logic [2:0] bi);
      exp_t e;
      e.st  = st;
      e.cc  = cc;
      e.ic  = ic;
      e.spc = spc;
      e.bi  = bi;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic tick();
      exp_t  e;
      string t;
      @(posedge sysClk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, "/status"}, 32'(status), 32'(e.st));
         chk({t, "/done"}, 32'(done), (e.st >= S_PASS) ? 32'd1 : 32'd0);
         chk({t, "/cycleCount"}, cycleCount, e.cc);
         chk({t, "/instrCount"}, instrCount, e.ic);
         chk({t, "/stopPC"}, stopPC, e.spc);
         chk({t, "/bpHitIdx"}, 32'(bpHitIdx), 32'(e.bi));
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] p);
      instrValid = v;
      instrData  = d;
      pc         = p;
   endtask

   // Clear back to IDLE, then release with en=1 to enter RUN with zeroed counters
   task automatic restart(input string tag);
      en    = 1'b1;
      clear = 1'b1;
      drive(1'b0, NOP, 32'h0);
      expect_out({tag, "_clr"}, S_IDLE, 0, 0, 32'h0, 3'd0);
      tick();
      clear = 1'b0;
      expect_out({tag, "_run"}, S_RUN, 0, 0, 32'h0, 3'd0);
      tick();
   endtask

   initial begin
      sysRes = 1'b0; en = 1'b0; clear = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      bpAddr = '0; bpEn = '0;
      tick();
      expect_out("reset", S_IDLE, 0, 0, 32'h0, 3'd0);
      tick();

      // Pass: 10 NOPs then ECALL
      sysRes = 1'b1; en = 1'b1;
      expect_out("run_entry", S_RUN, 0, 0, 32'h0, 3'd0);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, NOP, 32'(k * 4));
         if (k == 9) expect_out("nops", S_RUN, 10, 10, 32'h0, 3'd0);
         tick();
      end
      drive(1'b1, ECALL, 32'h28);
      expect_out("pass", S_PASS, 11, 11, 32'h28, 3'd0);
      tick();
      drive(1'b1, EBRK, 32'h40);
      expect_out("pass_hold", S_PASS, 11, 11, 32'h28, 3'd0);
      tick();
      en = 1'b0;
      drive(1'b0, NOP, 32'h44);
      expect_out("pass_hold_en0", S_PASS, 11, 11, 32'h28, 3'd0);
      tick();

      // Clear beats a simultaneous fail instruction, then counting restarts at 0
      en = 1'b1; clear = 1'b1;
      drive(1'b1, EBRK, 32'h48);
      expect_out("clear", S_IDLE, 0, 0, 32'h0, 3'd0);
      tick();
      clear = 1'b0;
      drive(1'b0, NOP, 32'h0);
      expect_out("restart", S_RUN, 0, 0, 32'h0, 3'd0);
      tick();
      drive(1'b1, NOP, 32'h0);
      expect_out("recount", S_RUN, 1, 1, 32'h0, 3'd0);
      tick();
      drive(1'b0, NOP, 32'h4);
      expect_out("recount_novalid", S_RUN, 2, 1, 32'h0, 3'd0);
      tick();

      // Fail outranks a breakpoint at the same PC
      restart("fail");
      bpAddr = {32'h0, 32'h40}; bpEn = 2'b01;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, NOP, 32'(32'h34 + k * 4));
         tick();
      end
      drive(1'b1, EBRK, 32'h40);
      expect_out("fail", S_FAIL, 4, 4, 32'h40, 3'd0);
      tick();

      // Breakpoints: only bp1 enabled, both enabled (lowest wins), none enabled
      restart("brk1");
      bpAddr = {32'h80, 32'h80}; bpEn = 2'b10;
      drive(1'b1, NOP, 32'h80);
      expect_out("break_bp1", S_BRK, 1, 1, 32'h80, 3'd1);
      tick();
      restart("brk0");
      bpEn = 2'b11;
      drive(1'b1, NOP, 32'h80);
      expect_out("break_lowest", S_BRK, 1, 1, 32'h80, 3'd0);
      tick();
      restart("nobrk");
      bpEn = 2'b00;
      drive(1'b1, NOP, 32'h80);
      tick();
      expect_out("no_break", S_RUN, 2, 2, 32'h0, 3'd0);
      tick();

      // Timeout after 20 RUN cycles
      restart("to");
      drive(1'b0, NOP, 32'h100);
      for (int k = 0; k < 19; k++) begin
         if (k == 18) expect_out("to_pre", S_RUN, 19, 0, 32'h0, 3'd0);
         tick();
      end
      expect_out("timeout", S_TO, 20, 0, 32'h100, 3'd0);
      tick();

      // Timeout delayed by 5 paused cycles; detection also paused
      restart("to_pause");
      drive(1'b0, NOP, 32'h200);
      for (int k = 0; k < 10; k++) tick();
      en = 1'b0;
      drive(1'b1, ECALL, 32'h200);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) expect_out("paused", S_RUN, 10, 0, 32'h0, 3'd0);
         tick();
      end
      en = 1'b1;
      drive(1'b0, NOP, 32'h204);
      for (int k = 0; k < 9; k++) begin
         if (k == 8) expect_out("to_late_pre", S_RUN, 19, 0, 32'h0, 3'd0);
         tick();
      end
      expect_out("timeout_late", S_TO, 20, 0, 32'h204, 3'd0);
      tick();
      en = 1'b0;
      expect_out("timeout_hold", S_TO, 20, 0, 32'h204, 3'd0);
      tick();

      // Reset mid-run overrides a pass instruction
      restart("rst");
      drive(1'b1, NOP, 32'h300);
      tick();
      tick();
      sysRes = 1'b0;
      drive(1'b1, ECALL, 32'h308);
      expect_out("reset_midrun", S_IDLE, 0, 0, 32'h0, 3'd0);
      tick();
      sysRes = 1'b1; en = 1'b0;
      drive(1'b0, NOP, 32'h0);
      expect_out("reset_after", S_IDLE, 0, 0, 32'h0, 3'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
